// File: rtl/cmp_pkg.sv
// Shared definitions for the serial comparator datapath: serializer FSM state
// encoding, {lt,eq,gt} flag ordering and the default operand MSB index that the
// serializer and comparator agree on.
package cmp_pkg;

  // Serializer control states.
  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } cmp_ser_state_e;

  // Bit positions of the comparator result flags, packed as {lt, eq, gt}.
  localparam int unsigned CmpFlagGt = 0;
  localparam int unsigned CmpFlagEq = 1;
  localparam int unsigned CmpFlagLt = 2;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Default MSB index; operands are CmpDefaultN+1 bits wide.
  localparam int unsigned CmpDefaultN = 3;

  // Width of a down-counter that must hold the values n..0.
  function automatic int unsigned cmp_cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Builds a flag triple from the outcome of a completed comparison.
  function automatic cmp_flags_t cmp_make_flags(input logic lt, input logic gt);
    cmp_flags_t f;
    f.lt = lt;
    f.gt = gt;
    f.eq = !lt && !gt;
    return f;
  endfunction

endpackage

// File: rtl/cmp_operand_slot.sv
// One-entry pending register for an operand pair. A write fills the slot, a read
// empties it; the owner never issues both in the same cycle because writes are
// only allowed while the slot is empty and reads only while it is full.
module cmp_operand_slot #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_full_next;

  // Occupancy: write sets, read clears; a write wins if both ever coincide.
  always_comb begin
    w_full_next = r_full;
    if (i_rd) begin
      w_full_next = 1'b0;
    end
    if (i_wr) begin
      w_full_next = 1'b1;
    end
  end

  // Occupancy flag register, emptied by reset so stale pairs are discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
    end else begin
      r_full <= w_full_next;
    end
  end

  // Payload register, captured on every write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_wr) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/cmp_operand_serializer.sv
// Operand serializer feeding the serial comparator. Accepts (a,b) pairs on a
// valid/ready handshake, holds one pair in a pending slot and streams both
// operands MSB-first, one bit-pair per beat, with first/last markers.
// Build option CMP_SER_EARLY_STOP_EN: when defined, the first beat whose bits
// differ is marked last and the remaining bits of that pair are dropped.
module cmp_operand_serializer
  import cmp_pkg::*;
#(
  parameter int unsigned N = CmpDefaultN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:0] a_in,
  input  logic [N:0] b_in,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       a_bit,
  output logic       b_bit,
  output logic       bit_first,
  output logic       bit_last,
  output logic       busy
);

  localparam int unsigned W    = N + 1;
  localparam int unsigned CntW = cmp_cnt_width(N);
  localparam logic [CntW-1:0] CntMax = CntW'(N);

  cmp_ser_state_e  r_state;
  cmp_ser_state_e  w_state_next;
  logic [N:0]      r_a_sh;
  logic [N:0]      r_b_sh;
  logic [N:0]      w_a_sh_next;
  logic [N:0]      w_b_sh_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  logic            w_pend_full;
  logic [2*W-1:0]  w_pend_data;
  logic            w_slot_wr;
  logic            w_slot_rd;

  logic            w_accept;
  logic            w_xfer;
  logic            w_last;
  logic            w_end;
  logic            w_shifter_free;
  logic            w_load;
  logic [N:0]      w_load_a;
  logic [N:0]      w_load_b;

  // Handshake and beat qualifiers. in_ready looks only at the registered slot
  // flag so upstream never sees a path from bit_ready.
  assign in_ready  = !w_pend_full;
  assign w_accept  = in_valid && in_ready;
  assign bit_valid = (r_state == StShift);
  assign w_xfer    = bit_valid && bit_ready;

`ifdef CMP_SER_EARLY_STOP_EN
  // A differing bit pair already decides the comparison, so it ends the pair.
  assign w_last = (r_cnt == '0) || (r_a_sh[N] != r_b_sh[N]);
`else
  assign w_last = (r_cnt == '0);
`endif

  assign w_end = w_xfer && w_last;

  // The shifter can take a new pair when idle or when its final beat leaves.
  assign w_shifter_free = (r_state == StIdle) || w_end;
  assign w_load         = w_shifter_free && (w_pend_full || w_accept);

  // Pending pair has priority; otherwise the accepted input bypasses the slot.
  assign w_load_a = w_pend_full ? w_pend_data[2*W-1:W] : a_in;
  assign w_load_b = w_pend_full ? w_pend_data[W-1:0]   : b_in;

  // An accepted pair parks in the slot only if the shifter cannot take it now.
  assign w_slot_wr = w_accept && !w_shifter_free;
  assign w_slot_rd = w_load && w_pend_full;

  cmp_operand_slot #(
    .W (2 * W)
  ) u_slot (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_wr    (w_slot_wr),
    .i_rd    (w_slot_rd),
    .i_data  ({a_in, b_in}),
    .o_full  (w_pend_full),
    .o_data  (w_pend_data)
  );

  // Next-state logic for the FSM, shifter and beat counter.
  always_comb begin
    w_state_next = r_state;
    w_a_sh_next  = r_a_sh;
    w_b_sh_next  = r_b_sh;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_state_next = StShift;
          w_a_sh_next  = w_load_a;
          w_b_sh_next  = w_load_b;
          w_cnt_next   = CntMax;
        end
      end
      StShift: begin
        if (w_end) begin
          if (w_load) begin
            // Next pair starts on the following cycle with no bubble.
            w_a_sh_next = w_load_a;
            w_b_sh_next = w_load_b;
            w_cnt_next  = CntMax;
          end else begin
            // Clear the shifter so idle outputs read as zero.
            w_state_next = StIdle;
            w_a_sh_next  = '0;
            w_b_sh_next  = '0;
            w_cnt_next   = '0;
          end
        end else if (w_xfer) begin
          w_a_sh_next = {r_a_sh[N-1:0], 1'b0};
          w_b_sh_next = {r_b_sh[N-1:0], 1'b0};
          w_cnt_next  = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, shifter and counter registers; reset drops any in-flight pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_a_sh  <= w_a_sh_next;
      r_b_sh  <= w_b_sh_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Beat outputs come straight from the shifter; markers are qualified by
  // bit_valid so they read zero while idle.
  assign a_bit     = r_a_sh[N];
  assign b_bit     = r_b_sh[N];
  assign bit_first = bit_valid && (r_cnt == CntMax);
  assign bit_last  = bit_valid && w_last;
  assign busy      = bit_valid || w_pend_full;

endmodule

// File: tb/tb_cmp_operand_serializer.sv
// Bench for cmp_operand_serializer: directed scenarios followed by random
// traffic, checked against a beat-queue model of the serializer.
module tb_cmp_operand_serializer;

  localparam int unsigned N = 3;
  localparam int unsigned W = N + 1;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         bit_ready = 1'b0;
  logic [N:0]   a_in      = '0;
  logic [N:0]   b_in      = '0;
  logic         in_ready;
  logic         bit_valid;
  logic         a_bit;
  logic         b_bit;
  logic         bit_first;
  logic         bit_last;
  logic         busy;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;

  // Expected beats in order, each {a, b, first, last}; plen_q holds the number
  // of beats still owed by each accepted pair (front = pair being streamed).
  logic [3:0]   beat_q[$];
  int           plen_q[$];

  always #5 clk = ~clk;

  cmp_operand_serializer #(
    .N (N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_first (bit_first),
    .bit_last  (bit_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expands a pair into the beats the serializer owes for it.
  task automatic model_push(input logic [N:0] a, input logic [N:0] b);
    int   cnt;
    logic last;
    cnt = 0;
    for (int i = int'(N); i >= 0; i--) begin
      last = (i == 0);
`ifdef CMP_SER_EARLY_STOP_EN
      if (a[i] != b[i]) last = 1'b1;
`endif
      beat_q.push_back({a[i], b[i], (i == int'(N)), last});
      cnt++;
      if (last) break;
    end
    plen_q.push_back(cnt);
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, advance model.
  task automatic step(input logic iv, input logic [N:0] a, input logic [N:0] b,
                      input logic br);
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    exp_valid = (plen_q.size() > 0);
    exp_ready = (plen_q.size() < 2);
    check("bit_valid", bit_valid, exp_valid);
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, exp_valid);
    if (exp_valid) begin
      check("a_bit", a_bit, beat_q[0][3]);
      check("b_bit", b_bit, beat_q[0][2]);
      check("bit_first", bit_first, beat_q[0][1]);
      check("bit_last", bit_last, beat_q[0][0]);
    end
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    bit_ready = br;
    if (br && exp_valid) begin
      void'(beat_q.pop_front());
      plen_q[0] = plen_q[0] - 1;
      if (plen_q[0] == 0) void'(plen_q.pop_front());
    end
    if (iv && exp_ready) model_push(a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_valid"}, bit_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_a_bit"}, a_bit, 1'b0);
    check({tag, "_b_bit"}, b_bit, 1'b0);
    check({tag, "_bit_first"}, bit_first, 1'b0);
    check({tag, "_bit_last"}, bit_last, 1'b0);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Single pair at full rate.
    step(1'b1, 4'hA, 4'h9, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Back-to-back pairs, third one must wait for the slot.
    step(1'b1, 4'hA, 4'hB, 1'b1);
    step(1'b1, 4'h5, 4'h6, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h3, 4'hC, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Stall for three cycles at beat 2.
    step(1'b1, 4'hC, 4'h3, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Equal operands.
    step(1'b1, 4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Reset at beat 2 with the pending slot full.
    step(1'b1, 4'hA, 4'hB, 1'b1);
    step(1'b1, 4'hC, 4'hD, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    beat_q.delete();
    plen_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 99) < 60), W'($urandom), W'($urandom),
           logic'($urandom_range(0, 99) < 75));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
